// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared constants and FSM state type for the PPU output packer
package ppu_pkg;
    localparam int DATA_BITS      = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int FIFO_DEPTH     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } packer_state_e;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; simultaneous push and pop is allowed even when full
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/ppu_packer.sv
// rtl/ppu_packer.sv - packs the PPU byte stream into little-endian GLB words with byte strobes
module ppu_packer #(
    parameter int DATA_BITS  = ppu_pkg::DATA_BITS,
    parameter int FIFO_DEPTH = ppu_pkg::FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    input  logic [15:0]          num_bytes,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 glb_wvalid,
    output logic [31:0]          glb_waddr,
    output logic [DATA_BITS-1:0] glb_wdata,
    output logic [3:0]           glb_wstrb,
    input  logic                 glb_wready,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    import ppu_pkg::*;

    localparam int NB = BYTES_PER_WORD;
    localparam int LW = $clog2(NB);

    packer_state_e          state_q, state_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [15:0]            count_q, count_d, len_q, len_d;
    logic [DATA_BITS-1:0]   word_q, word_d, word_fill;
    logic [NB-1:0]          strb_q, strb_d, strb_fill;
    logic [31:0]            waddr_q, waddr_d;
    logic                   ovf_q, ovf_d;
    logic                   accept, last, push, pop, fifo_full, fifo_empty;
    logic [DATA_BITS+NB-1:0] head;

    sync_fifo #(.WIDTH(DATA_BITS + NB), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({strb_fill, word_fill}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        word_fill = word_q;
        word_fill[8*lane_q +: 8] = in_data;
        strb_fill = strb_q | (NB'(1) << lane_q);
        accept    = in_valid && (state_q == PACK);
        last      = (count_q == len_q - 16'd1);
        push      = accept && ((lane_q == LW'(NB - 1)) || last);
        pop       = glb_wready && !fifo_empty;
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        count_d = count_q;
        len_d   = len_q;
        word_d  = word_q;
        strb_d  = strb_q;
        waddr_d = pop ? waddr_q + 32'd4 : waddr_q;
        ovf_d   = ovf_q || (push && fifo_full && !pop);
        case (state_q)
            IDLE: if (start) begin
                len_d   = num_bytes;
                count_d = '0;
                lane_d  = '0;
                word_d  = '0;
                strb_d  = '0;
                waddr_d = base_addr;
                ovf_d   = 1'b0;
                state_d = (num_bytes == 16'd0) ? DONE : PACK;
            end
            PACK: if (accept) begin
                count_d = count_q + 16'd1;
                lane_d  = lane_q + 1'b1;
                // Clear the assembly register on push so unfilled lanes of the next word read 0
                word_d  = push ? '0 : word_fill;
                strb_d  = push ? '0 : strb_fill;
                if (last) state_d = DRAIN;
            end
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            word_q  <= '0;
            strb_q  <= '0;
            waddr_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            count_q <= count_d;
            len_q   <= len_d;
            word_q  <= word_d;
            strb_q  <= strb_d;
            waddr_q <= waddr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign glb_wvalid = !fifo_empty;
    assign glb_waddr  = waddr_q;
    assign glb_wdata  = fifo_empty ? '0 : head[DATA_BITS-1:0];
    assign glb_wstrb  = fifo_empty ? '0 : head[DATA_BITS +: NB];
    assign busy       = (state_q == PACK) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_ppu_packer.sv
// tb/tb_ppu_packer.sv - randomized and directed bench for ppu_packer against a queue-based model
module tb_ppu_packer;
    localparam int DB    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [15:0]   num_bytes = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          glb_wready = 1'b0;
    logic          glb_wvalid, busy, done, overflow;
    logic [31:0]   glb_waddr;
    logic [DB-1:0] glb_wdata;
    logic [3:0]    glb_wstrb;

    always #5 clk = ~clk;

    ppu_packer #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_bytes(num_bytes),
        .in_valid(in_valid), .in_data(in_data), .glb_wvalid(glb_wvalid), .glb_waddr(glb_waddr),
        .glb_wdata(glb_wdata), .glb_wstrb(glb_wstrb), .glb_wready(glb_wready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;
    int rdy_pct = 100;

    // Model: 0 idle, 1 packing, 2 draining, 3 done
    int          m_phase = 0;
    int          m_cnt = 0;
    int          m_len = 0;
    logic [31:0] m_addr = '0;
    logic        m_ovf = 1'b0;
    logic [35:0] mq[$];
    logic [7:0]  parts[$];
    logic [67:0] dut_wr[$];

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] pack_word();
        logic [31:0] w = '0;
        logic [3:0]  s = '0;
        foreach (parts[i]) begin
            w[8*i +: 8] = parts[i];
            s[i] = 1'b1;
        end
        return {s, w};
    endfunction

    function automatic logic [67:0] wr_at(input int i);
        return (i < dut_wr.size()) ? dut_wr[i] : '1;
    endfunction

    task automatic model_step();
        logic        pop_m = glb_wready && (mq.size() > 0);
        logic        have_push = 1'b0;
        logic [35:0] pw = '0;
        if (rst) begin
            mq.delete(); parts.delete();
            m_phase = 0; m_addr = '0; m_ovf = 1'b0; m_cnt = 0;
            return;
        end
        case (m_phase)
            0: if (start) begin
                m_addr = base_addr; m_ovf = 1'b0; m_len = num_bytes; m_cnt = 0;
                parts.delete();
                m_phase = (num_bytes == 0) ? 3 : 1;
            end
            1: if (in_valid) begin
                parts.push_back(in_data);
                m_cnt++;
                if (parts.size() == 4 || m_cnt == m_len) begin
                    pw = pack_word(); have_push = 1'b1; parts.delete();
                end
                if (m_cnt == m_len) m_phase = 2;
            end
            2: if (mq.size() == 0) m_phase = 3;
            default: m_phase = 0;
        endcase
        if (pop_m) begin
            void'(mq.pop_front());
            m_addr += 32'd4;
        end
        if (have_push) begin
            if (mq.size() < DEPTH) mq.push_back(pw);
            else m_ovf = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (!rst && glb_wvalid && glb_wready) dut_wr.push_back({glb_waddr, glb_wstrb, glb_wdata});
        model_step();
        #1;
        chk("wvalid", glb_wvalid, mq.size() > 0);
        chk("waddr", glb_waddr, m_addr);
        chk("busy", busy, m_phase == 1 || m_phase == 2);
        chk("done", done, m_phase == 3);
        chk("overflow", overflow, m_ovf);
        if (mq.size() > 0) begin
            chk("wdata", glb_wdata, mq[0][31:0]);
            chk("wstrb", glb_wstrb, mq[0][35:32]);
        end
    end

    task automatic tick();
        @(negedge clk);
        glb_wready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic start_job(input logic [31:0] b, input logic [15:0] n);
        start = 1'b1; base_addr = b; num_bytes = n;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] bytes[$], input int gap_pct);
        foreach (bytes[i]) begin
            while ($urandom_range(99) < gap_pct) tick();
            in_valid = 1'b1; in_data = bytes[i];
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(nm, done, 1'b1);
        tick();
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {glb_wvalid, glb_waddr, glb_wdata, glb_wstrb, busy, done, overflow}, '0);
    endtask

    initial begin
        logic [7:0] b[$];
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_all_zero("reset_state");

        // Two full words back-to-back
        dut_wr.delete(); b.delete();
        for (int i = 1; i <= 8; i++) b.push_back(8'(i));
        start_job(32'h100, 16'd8); feed(b, 0); wait_done("t1_done", 100);
        chk("t1_nwr", dut_wr.size(), 2);
        chk("t1_w0", wr_at(0), {32'h100, 4'hF, 32'h04030201});
        chk("t1_w1", wr_at(1), {32'h104, 4'hF, 32'h08070605});

        // Partial final word
        dut_wr.delete(); b.delete();
        for (int i = 0; i < 6; i++) b.push_back(8'hA0 + 8'(i));
        start_job(32'h200, 16'd6); feed(b, 0); wait_done("t2_done", 100);
        chk("t2_w1", wr_at(1), {32'h204, 4'h3, 32'h0000A5A4});

        // Overflow: GLB stalls for the whole job
        dut_wr.delete(); b.delete();
        for (int i = 1; i <= 24; i++) b.push_back(8'(i));
        rdy_pct = 0;
        start_job(32'h800, 16'd24); feed(b, 0); repeat (4) tick();
        rdy_pct = 100;
        wait_done("t3_done", 100);
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_nwr", dut_wr.size(), DEPTH);
        chk("t3_w0", wr_at(0), {32'h800, 4'hF, 32'h04030201});
        chk("t3_w3", wr_at(3), {32'h80C, 4'hF, 32'h100F0E0D});

        // Zero-length job
        dut_wr.delete();
        start_job(32'h40, 16'd0);
        chk("t4_done_pulse", done, 1'b1);
        tick();
        chk("t4_done_off", done, 1'b0);
        chk("t4_nwr", dut_wr.size(), 0);

        // Reset mid-job, then a fresh single-word job
        b.delete();
        for (int i = 1; i <= 5; i++) b.push_back(8'(i));
        rdy_pct = 0;
        start_job(32'h300, 16'd8); feed(b, 0);
        rst = 1'b1; tick();
        chk_all_zero("t5_in_reset");
        rst = 1'b0; rdy_pct = 100; tick();
        chk_all_zero("t5_after_reset");
        dut_wr.delete();
        start_job(32'h400, 16'd4); feed('{8'h11, 8'h22, 8'h33, 8'h44}, 0); wait_done("t5_done", 100);
        chk("t5_nwr", dut_wr.size(), 1);
        chk("t5_w0", wr_at(0), {32'h400, 4'hF, 32'h44332211});

        // Start while busy is ignored; bytes while idle are ignored
        dut_wr.delete();
        start_job(32'h500, 16'd8); feed('{8'h01, 8'h02, 8'h03}, 0);
        start = 1'b1; base_addr = 32'h900; num_bytes = 16'd2; in_valid = 1'b1; in_data = 8'h04;
        tick();
        start = 1'b0; in_valid = 1'b0;
        feed('{8'h05, 8'h06, 8'h07, 8'h08}, 0); wait_done("t6_done", 100);
        feed('{8'hEE, 8'hEE, 8'hEE}, 0);
        start_job(32'h600, 16'd4); feed('{8'h0A, 8'h0B, 8'h0C, 8'h0D}, 0); wait_done("t6b_done", 100);
        chk("t6_nwr", dut_wr.size(), 3);
        chk("t6_w0", wr_at(0), {32'h500, 4'hF, 32'h04030201});
        chk("t6_w1", wr_at(1), {32'h504, 4'hF, 32'h08070605});
        chk("t6_w2", wr_at(2), {32'h600, 4'hF, 32'h0D0C0B0A});

        // Address wraps past 2^32
        dut_wr.delete(); b.delete();
        for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
        start_job(32'hFFFF_FFF8, 16'd12); feed(b, 20); wait_done("t7_done", 200);
        chk("t7_wrap_addr", wr_at(2) >> 36, 68'h0);

        // Random jobs with stalls and input gaps
        for (int j = 0; j < 12; j++) begin
            int n = $urandom_range(1, 24);
            b.delete();
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            rdy_pct = $urandom_range(30, 100);
            start_job($urandom & 32'hFFFF_FFFC, 16'(n));
            feed(b, $urandom_range(0, 50));
            rdy_pct = 100;
            wait_done("rnd_done", 400);
            feed('{8'($urandom), 8'($urandom)}, 30);
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ppu_packer.md
PPU_PACKER -- requirements
Module: ppu_packer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32, GLB word width; 4 bytes per word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, word FIFO entries.
REQ-003 SHALL have ports clk (input, 1, sole clock) and rst (input, 1). rst is synchronous and active-high.
REQ-004 SHALL have port start (input, 1): one-cycle pulse that begins a job.
REQ-005 SHALL have port base_addr (input, 32): GLB byte address of the first word, 4-byte aligned, sampled on start.
REQ-006 SHALL have port num_bytes (input, 16): job length in bytes, sampled on start.
REQ-007 SHALL have ports in_valid (input, 1) and in_data (input, 8): quantized byte from the PPU valid/data_out pair; no backpressure.
REQ-008 SHALL have ports glb_wvalid (output, 1), glb_waddr (output, 32), glb_wdata (output, DATA_BITS) and glb_wstrb (output, 4): GLB write request.
REQ-009 SHALL have port glb_wready (input, 1): GLB accepts the write.
REQ-010 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and overflow (output, 1, sticky).

Function
REQ-011 SHALL use FSM states IDLE, PACK, DRAIN and DONE; DONE lasts one cycle and asserts done, then the FSM returns to IDLE.
REQ-012 On start in IDLE, SHALL go to PACK: latch base_addr and num_bytes, clear lane index and byte count; if num_bytes==0, go directly to DONE.
REQ-013 SHALL ignore start in any state other than IDLE.
REQ-014 In PACK, each in_valid cycle SHALL place in_data in lane k at bits [8k+7:8k] (little-endian), then k increments modulo 4.
REQ-015 SHALL ignore in_valid outside PACK, with no state change.
REQ-016 On the cycle the lane-3 byte or the final byte (count==num_bytes-1) arrives, SHALL push {word, strb} into the FIFO; strb bit k is set for every filled lane; unfilled lanes are 0.
REQ-017 After pushing the final byte, SHALL go from PACK to DRAIN.
REQ-018 glb_wvalid SHALL equal FIFO not empty; glb_wdata and glb_wstrb SHALL be the FIFO head; a word is visible the cycle after its completing byte.
REQ-019 SHALL pop the FIFO and advance glb_waddr by 4 on glb_wvalid&&glb_wready; glb_waddr SHALL start at the latched base_addr and wrap modulo 2^32.
REQ-020 While glb_wvalid is high and glb_wready is low, glb_wdata, glb_wstrb and glb_waddr SHALL stay stable.
REQ-021 When push and pop occur in the same cycle, both SHALL happen, including when the FIFO is full.
REQ-022 A push to a full FIFO with no pop SHALL drop the word and set overflow; overflow SHALL hold until rst or the next accepted start; the job still completes.
REQ-023 SHALL go from DRAIN to DONE on the cycle after the FIFO becomes empty.
REQ-024 busy SHALL be high in PACK and DRAIN and low in IDLE and DONE.

Reset
REQ-025 rst SHALL force IDLE, an empty FIFO, k=0, count=0, glb_waddr=0, and glb_wvalid, done, busy and overflow all 0, including mid-job; in-flight words SHALL be discarded.
REQ-026 All outputs SHALL be 0 in the cycle after rst deasserts until start.

Structure
REQ-027 Package ppu_pkg SHALL hold DATA_BITS, BYTES_PER_WORD=4, FIFO_DEPTH and the packer_state_e enum.
REQ-028 SHALL instantiate one sub-module, sync_fifo: width DATA_BITS+4, depth FIFO_DEPTH, with push/pop/full/empty ports.
REQ-029 SHALL contain no combinational path from in_valid to glb_wvalid.

Verification
REQ-030 Test: start, base 0x100, num_bytes=8, bytes 0x01..0x08 back-to-back, glb_wready=1 -> writes 0x04030201@0x100 and 0x08070605@0x104, strb 0xF, then done.
REQ-031 Test: num_bytes=6, bytes 0xA0..0xA5 -> second write is 0x0000A5A4@base+4 with strb 0x3.
REQ-032 Test: glb_wready=0 for 20 cycles, 24 bytes -> overflow=1 with exactly FIFO_DEPTH words written in order after ready rises, and done still asserted.
REQ-033 Test: num_bytes=0 -> done pulses 1 cycle after start; no glb_wvalid.
REQ-034 Test: rst asserted after 5 of 8 bytes -> all outputs 0 next cycle; a fresh 4-byte job then writes a correct single word.
REQ-035 Test: start while busy and in_valid while IDLE -> no effect on addresses, data or count.
